fixed_point_addsub_arbiter: RTL and testbench

//  Shares one combinational fixed-point add/subtract unit among R requesters.

---
 rtl/fixed_point_addsub_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fixed_point_addsub_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_addsub_arbiter.sv
// Round-robin shared fixed-point add/subtract unit with a one-entry registered result.
// Optional macro FIXED_POINT_ARB_OVERFLOW_EN adds the registered signed-overflow flag rsp_ovf.

module fixed_point_adder #(
  parameter int N     = 32,
  parameter     MODEL = "Structural",
  parameter     TOP   = "RippleCarryAdd"
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] c,
  output logic         co
);
  generate
    if (MODEL == "Structural" && TOP == "RippleCarryAdd") begin : g_ripple
      logic [N:0] carry;
      assign carry[0] = ci;
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign c[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      assign co = carry[N];
    end else begin : g_behavioural
      assign {co, c} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    end
  endgenerate
endmodule

module fixed_point_addsub_arbiter #(
  parameter int N     = 32,
  parameter int R     = 4,
  parameter     MODEL = "Structural",
  parameter     TOP   = "RippleCarryAdd",
  localparam int IDW  = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R-1:0]   req_subtract,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [N-1:0]   rsp_c,
  output logic           rsp_co
`ifdef FIXED_POINT_ARB_OVERFLOW_EN
  ,
  output logic           rsp_ovf
`endif
);
  // Handshake: a transfer happens on a rising edge where valid && ready on the same side;
  // requesters hold valid and operands until ready, and ready never depends on a future cycle.

  typedef enum logic {EMPTY, FULL} state_t;

  // Output register occupancy; kept as a named register so checkers can observe it.
  state_t         state;
  logic [IDW-1:0] rr_ptr;

  logic [N-1:0]   a_arr [R];
  logic [N-1:0]   b_arr [R];

  generate
    for (genvar i = 0; i < R; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*N +: N];
      assign b_arr[i] = req_b[i*N +: N];
    end
  endgenerate

  logic           can_accept;
  logic           any_valid;
  logic           accept;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_next;
  logic [IDW:0]   cand;

  assign can_accept = (state == EMPTY) || rsp_ready;

  // First pending requester at or after rr_ptr, wrapping modulo R.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 0; k < R; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(R)) cand = cand - (IDW+1)'(R);
      if (!any_valid && req_valid[cand[IDW-1:0]]) begin
        any_valid = 1'b1;
        grant     = cand[IDW-1:0];
      end
    end
  end

  assign accept   = !rst && can_accept && any_valid;
  assign ptr_next = (grant == IDW'(R-1)) ? '0 : grant + IDW'(1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < R; i++) begin
      req_ready[i] = accept && (grant == IDW'(i));
    end
  end

  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_sub;
  logic [N-1:0] sum_c;
  logic         sum_co;

  assign op_a   = a_arr[grant];
  assign op_sub = req_subtract[grant];
  // Subtract is a + ~b + 1: invert b and feed the op bit as carry-in.
  assign op_b   = op_sub ? ~b_arr[grant] : b_arr[grant];

  fixed_point_adder #(
    .N     (N),
    .MODEL (MODEL),
    .TOP   (TOP)
  ) u_adder (
    .a  (op_a),
    .b  (op_b),
    .ci (op_sub),
    .c  (sum_c),
    .co (sum_co)
  );

`ifdef FIXED_POINT_ARB_OVERFLOW_EN
  logic sum_ovf;
  assign sum_ovf = (op_a[N-1] == op_b[N-1]) && (sum_c[N-1] != op_a[N-1]);
`endif

  assign rsp_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      rr_ptr  <= '0;
      rsp_id  <= '0;
      rsp_c   <= '0;
      rsp_co  <= 1'b0;
`ifdef FIXED_POINT_ARB_OVERFLOW_EN
      rsp_ovf <= 1'b0;
`endif
    end else if (accept) begin
      state   <= FULL;
      rr_ptr  <= ptr_next;
      rsp_id  <= grant;
      rsp_c   <= sum_c;
      rsp_co  <= sum_co;
`ifdef FIXED_POINT_ARB_OVERFLOW_EN
      rsp_ovf <= sum_ovf;
`endif
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_fixed_point_addsub_arbiter.sv
// Bench for fixed_point_addsub_arbiter: directed cases then randomized traffic against a queue model.
// Honours FIXED_POINT_ARB_OVERFLOW_EN when the design is built with it.

module tb_fixed_point_addsub_arbiter;
  localparam int N   = 32;
  localparam int R   = 4;
  localparam int IDW = 2;
  localparam int W   = N + IDW + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R-1:0]   req_subtract;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0]   rsp_c;
  logic           rsp_co;
`ifdef FIXED_POINT_ARB_OVERFLOW_EN
  logic           rsp_ovf;
`endif

  fixed_point_addsub_arbiter #(.N(N), .R(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_subtract (req_subtract),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_c        (rsp_c),
    .rsp_co       (rsp_co)
`ifdef FIXED_POINT_ARB_OVERFLOW_EN
    , .rsp_ovf    (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: entry = {ovf, id, co, c}; head is the result the DUT must be presenting.
  logic [W-1:0] exp_q[$];
  int           m_ptr = 0;
  int           last_grant = -1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_result(int g);
    logic [N-1:0] a, b, c;
    logic [N:0]   wide;
    logic         co, ovf;
    a = req_a[g*N +: N];
    b = req_b[g*N +: N];
    if (req_subtract[g]) begin
      c   = a - b;
      co  = (a >= b);
      ovf = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      c    = wide[N-1:0];
      co   = wide[N];
      ovf  = (a[N-1] == b[N-1]) && (c[N-1] != a[N-1]);
    end
    return {ovf, IDW'(g), co, c};
  endfunction

  // Called just after an active edge with inputs already driven; returns just after the next edge.
  task automatic cycle();
    logic [R-1:0] exp_ready;
    logic [W-1:0] head;
    int           g;
    bit           was_rst;
    #1;
    exp_ready = '0;
    g         = -1;
    was_rst   = rst;
    if (!rst && (exp_q.size() == 0 || rsp_ready)) begin
      for (int k = 0; k < R; k++) begin
        int idx;
        idx = (m_ptr + k) % R;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    last_grant = g;
    if (rst) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_q.size() > 0 && rsp_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(model_result(g));
        m_ptr = (g + 1) % R;
      end
    end
    @(posedge clk);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("rsp_id", 64'(rsp_id), 64'(head[N+IDW:N+1]));
      check("rsp_c", 64'(rsp_c), 64'(head[N-1:0]));
      check("rsp_co", 64'(rsp_co), 64'(head[N]));
`ifdef FIXED_POINT_ARB_OVERFLOW_EN
      check("rsp_ovf", 64'(rsp_ovf), 64'(head[W-1]));
`endif
    end else if (was_rst) begin
      check("rst_id", 64'(rsp_id), 64'd0);
      check("rst_c", 64'(rsp_c), 64'd0);
      check("rst_co", 64'(rsp_co), 64'd0);
    end
  endtask

  task automatic set_req(int i, bit v, bit sub, logic [N-1:0] a, logic [N-1:0] b);
    req_valid[i]      = v;
    req_subtract[i]   = sub;
    req_a[i*N +: N]   = a;
    req_b[i*N +: N]   = b;
  endtask

  function automatic logic [N-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_subtract = '0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with every requester asking.
    req_valid = '1;
    cycle();
    cycle();
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_c", 64'(rsp_c), 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    set_req(0, 1'b1, 1'b0, 32'd5, 32'd3);
    cycle();
    check("add_c", 64'(rsp_c), 64'd8);
    check("add_co", 64'(rsp_co), 64'd0);
    check("add_id", 64'(rsp_id), 64'd0);

    req_valid = '0;
    set_req(2, 1'b1, 1'b1, 32'd3, 32'd5);
    cycle();
    check("sub_neg_c", 64'(rsp_c), 64'hFFFF_FFFE);
    check("sub_neg_co", 64'(rsp_co), 64'd0);
    check("sub_neg_id", 64'(rsp_id), 64'd2);

    set_req(2, 1'b1, 1'b1, 32'd5, 32'd3);
    cycle();
    check("sub_pos_c", 64'(rsp_c), 64'd2);
    check("sub_pos_co", 64'(rsp_co), 64'd1);

    req_valid = '0;
    cycle();
    check("drain_empty", 64'(rsp_valid), 64'd0);

    // Round robin from a fresh pointer with all four requesters continuously valid.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < R; i++) set_req(i, 1'b1, 1'b0, 32'h100 * (i + 1), 32'(i + 1));
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_id", 64'(rsp_id), 64'(k % R));
      check("rr_valid", 64'(rsp_valid), 64'd1);
    end

    // Backpressure: result from requester 0 (0x100 + 1) must hold for three cycles.
    rsp_ready = 1'b0;
    req_valid = '0;
    set_req(1, 1'b1, 1'b1, 32'd100, 32'd40);
    set_req(3, 1'b1, 1'b0, 32'd7, 32'd8);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_id", 64'(rsp_id), 64'd0);
      check("hold_c", 64'(rsp_c), 64'h101);
    end
    rsp_ready = 1'b1;
    cycle();
    check("release_id", 64'(rsp_id), 64'd1);
    check("release_c", 64'(rsp_c), 64'd60);
    check("release_co", 64'(rsp_co), 64'd1);
    req_valid = '0;
    cycle();
    cycle();

`ifdef FIXED_POINT_ARB_OVERFLOW_EN
    set_req(0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
    cycle();
    check("ovf_add_c", 64'(rsp_c), 64'h8000_0000);
    check("ovf_add_flag", 64'(rsp_ovf), 64'd1);
    req_valid = '0;
    set_req(1, 1'b1, 1'b1, 32'd0, 32'd1);
    cycle();
    check("ovf_sub_flag", 64'(rsp_ovf), 64'd0);
    req_valid = '0;
    cycle();
`endif

    // Randomized traffic: operands change only when a requester is idle or just accepted.
    for (int t = 0; t < 400; t++) begin
      rst       = ($urandom_range(0, 63) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < R; i++) begin
        if (!req_valid[i] || last_grant == i)
          set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_operand(), rand_operand());
        else if ($urandom_range(0, 15) == 0)
          req_valid[i] = 1'b0;
      end
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
